// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbitration slice.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam int UART_FRAME_BITS        = 10;
    localparam int UART_DATA_BITS         = 8;
    localparam int DEFAULT_GAP_CYCLES     = 1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner select over a request vector; the pointer moves past the
// winner only when the caller reports an actual transfer.
module uart_rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               txclk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [NUM_REQ-1:0]   lowest_s;
    int                   off_s;
    int                   sum_s;

    // Rotate requests so ptr sits at bit 0, isolate the lowest set bit, map back.
    always_comb begin
        dbl_s    = {req, req} >> ptr_q;
        rot_s    = dbl_s[NUM_REQ-1:0];
        lowest_s = rot_s & (~rot_s + {{(NUM_REQ-1){1'b0}}, 1'b1});
        off_s    = 32'sd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            off_s = off_s | (lowest_s[k] ? k : 32'sd0);
        end
        sum_s   = int'(ptr_q) + off_s;
        winner  = IDX_W'((sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s);
        any_req = |req;
        ptr_d   = advance ? IDX_W'(wrap_inc(int'(winner), NUM_REQ)) : ptr_q;
    end

    // Priority pointer register.
    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NUM_REQ byte producers: round-robin grant,
// load strobe, gated shift enable, inter-frame gap and a per-frame watchdog.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                   txclk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   ld_tx_data,
    output logic [7:0]             tx_data,
    output logic                   tx_enable,
    input  logic                   tx_empty,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   frame_done,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);

    tx_state_e        state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             ld_q, ld_d;
    logic             tx_enable_q, tx_enable_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_ok_s;
    logic             set_timeout_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] ptr_s;
    logic             any_req_s;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .txclk   (txclk),
        .reset   (reset),
        .req     (req_valid),
        .advance (grant_ok_s),
        .ptr     (ptr_s),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Grant qualification and the one-hot ready toward the winning producer.
    always_comb begin
        grant_ok_s = (state_q == ST_IDLE) & en & tx_empty & ~timeout_q & any_req_s;
        if (grant_ok_s) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        ld_d          = 1'b0;
        tx_enable_d   = tx_enable_q;
        frame_done_d  = 1'b0;
        cnt_d         = cnt_q;
        set_timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_enable_d = 1'b0;
                if (grant_ok_s) begin
                    tx_data_d  = req_data[int'(winner_s)*8 +: 8];
                    grant_id_d = winner_s;
                    ld_d       = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_enable_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                tx_enable_d = 1'b1;
                if (tx_empty) begin
                    tx_enable_d  = 1'b0;
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Serializer never drained: abandon the frame without frame_done.
                    set_timeout_s = 1'b1;
                    tx_enable_d   = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                tx_enable_d = 1'b0;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                tx_enable_d = 1'b0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase

        // A new hang outranks a simultaneous clear.
        if (set_timeout_s) begin
            timeout_d = 1'b1;
        end else if (err_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= 8'h00;
            grant_id_q   <= '0;
            ld_q         <= 1'b0;
            tx_enable_q  <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            ld_q         <= ld_d;
            tx_enable_q  <= tx_enable_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ld_tx_data  = ld_q;
    assign tx_data     = tx_data_q;
    assign tx_enable   = tx_enable_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 10-bit UART serializer stub.
module tb_uart_tx_arbiter;

    logic        txclk;
    logic        reset;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ld_tx_data;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_empty;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic        timeout_err;
    logic        err_clr;

    logic        ser_empty;
    logic        ser_line;
    logic [7:0]  ser_shreg;
    int          ser_cnt;
    logic        stall;

    int n_assert;
    int n_fail;
    int cyc;
    int fd_cnt;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .txclk       (txclk),
        .reset       (reset),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    assign tx_empty = ser_empty & ~stall;

    // Serializer stub: start, 8 data LSB first, stop; counter cleared while disabled.
    always @(posedge txclk or posedge reset) begin
        if (reset) begin
            ser_empty <= 1'b1;
            ser_cnt   <= 0;
            ser_line  <= 1'b1;
            ser_shreg <= 8'h00;
        end else if (ld_tx_data) begin
            ser_shreg <= tx_data;
            ser_empty <= 1'b0;
            ser_cnt   <= 0;
        end else if (!tx_enable) begin
            ser_cnt  <= 0;
            ser_line <= 1'b1;
        end else if (!ser_empty) begin
            if (ser_cnt == 0) ser_line <= 1'b0;
            else if (ser_cnt <= 8) ser_line <= ser_shreg[ser_cnt-1];
            else ser_line <= 1'b1;
            if (ser_cnt == 9) ser_empty <= 1'b1;
            ser_cnt <= ser_cnt + 1;
        end
    end

    always @(posedge txclk) begin
        cyc <= cyc + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ld(input string tag);
        int i;
        i = 0;
        while (ld_tx_data !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check({tag, " ld_seen"}, 32'(ld_tx_data), 32'd1);
    endtask

    task automatic wait_fd(input string tag);
        int i;
        i = 0;
        while (frame_done !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check({tag, " fd_seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < 60) begin
            tick();
            i++;
        end
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [9:0] bits;
        int         t_prev;
        int         fd0;

        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        fd_cnt    = 0;
        reset     = 1'b1;
        en        = 1'b0;
        req_valid = 4'h0;
        req_data  = 32'h0;
        err_clr   = 1'b0;
        stall     = 1'b0;
        bits      = 10'h0;
        t_prev    = 0;

        #2;
        check("rst ld", 32'(ld_tx_data), 32'd0);
        check("rst tx_enable", 32'(tx_enable), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst timeout", 32'(timeout_err), 32'd0);
        #10 reset = 1'b0;
        tick();

        // Single frame from requester 2, byte A5, line checked bit by bit.
        en        = 1'b1;
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        #1;
        check("t1 ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        check("t1 ld", 32'(ld_tx_data), 32'd1);
        check("t1 grant", 32'(grant_id), 32'd2);
        check("t1 data", 32'(tx_data), 32'hA5);
        tick();
        check("t1 ld_pulse", 32'(ld_tx_data), 32'd0);
        check("t1 txen", 32'(tx_enable), 32'd1);
        check("t1 line_idle", 32'(ser_line), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            bits[i] = ser_line;
        end
        check("t1 line_bits", 32'(bits), 32'h34A);
        check("t1 fd_early", 32'(frame_done), 32'd0);
        tick();
        check("t1 fd", 32'(frame_done), 32'd1);
        check("t1 txen_off", 32'(tx_enable), 32'd0);
        tick();
        check("t1 fd_once", 32'(frame_done), 32'd0);
        check("t1 idle", 32'(busy), 32'd0);
        check("t1 fd_cnt", 32'(fd_cnt), 32'd1);

        // Fresh reset so the pointer starts at 0; all four request continuously.
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        req_data  = 32'h4433_2211;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ld("t2");
            check($sformatf("t2 grant%0d", k), 32'(grant_id), 32'(k % 4));
            check($sformatf("t2 data%0d", k), 32'(tx_data), 32'(8'h11 * (k % 4 + 1)));
            if (k > 0) check($sformatf("t2 period%0d", k), 32'(cyc - t_prev), 32'd14);
            t_prev = cyc;
            if (k < 4) begin
                wait_fd("t2");
                check("t2 gap_txen", 32'(tx_enable), 32'd0);
                check("t2 gap_busy", 32'(busy), 32'd1);
                tick();
                check("t2 gap_len", 32'(busy), 32'd0);
            end
        end
        req_valid = 4'h0;
        wait_idle("t2");

        // Pointer at 1: lone requester 3, then 0 and 3 together.
        req_valid = 4'b1000;
        wait_ld("t3a");
        check("t3 grant3", 32'(grant_id), 32'd3);
        req_valid = 4'b1001;
        tick();
        wait_ld("t3b");
        check("t3 grant0", 32'(grant_id), 32'd0);
        tick();
        wait_ld("t3c");
        check("t3 grant3b", 32'(grant_id), 32'd3);
        req_valid = 4'h0;
        wait_idle("t3");

        // Stalled serializer trips the watchdog after 16 SEND cycles.
        req_valid = 4'b0010;
        wait_ld("t4");
        check("t4 grant1", 32'(grant_id), 32'd1);
        stall = 1'b1;
        fd0   = fd_cnt;
        for (int i = 0; i < 16; i++) tick();
        check("t4 no_to_yet", 32'(timeout_err), 32'd0);
        check("t4 still_send", 32'(tx_enable), 32'd1);
        tick();
        check("t4 timeout", 32'(timeout_err), 32'd1);
        check("t4 txen_off", 32'(tx_enable), 32'd0);
        check("t4 no_fd", 32'(frame_done), 32'd0);
        tick();
        check("t4 idle", 32'(busy), 32'd0);
        check("t4 blocked", 32'(req_ready), 32'd0);
        stall = 1'b0;
        #1;
        check("t4 blocked_sticky", 32'(req_ready), 32'd0);
        tick();
        check("t4 still_blocked", 32'(ld_tx_data), 32'd0);
        check("t4 fd_cnt", 32'(fd_cnt), 32'(fd0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("t4 cleared", 32'(timeout_err), 32'd0);
        check("t4 ready", 32'(req_ready), 32'h2);
        tick();
        check("t4 regrant", 32'(ld_tx_data), 32'd1);
        req_valid = 4'h0;
        wait_idle("t4");

        // en dropped during data bit 4: frame completes, no new grant until restored.
        req_valid = 4'b0101;
        wait_ld("t5");
        check("t5 grant2", 32'(grant_id), 32'd2);
        for (int i = 0; i < 7; i++) tick();
        en = 1'b0;
        wait_fd("t5");
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5 no_ready", 32'(req_ready), 32'd0);
            check("t5 no_busy", 32'(busy), 32'd0);
            tick();
        end
        en = 1'b1;
        #1;
        check("t5 ready0", 32'(req_ready), 32'h1);
        tick();
        check("t5 grant0", 32'(grant_id), 32'd0);
        req_valid = 4'h0;
        wait_idle("t5");

        // Reset mid-SEND clears outputs at once and restores requester-0 priority.
        req_valid = 4'b0100;
        wait_ld("t6");
        check("t6 grant2", 32'(grant_id), 32'd2);
        req_valid = 4'h0;
        for (int i = 0; i < 3; i++) tick();
        check("t6 sending", 32'(tx_enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6 txen", 32'(tx_enable), 32'd0);
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 grant_id", 32'(grant_id), 32'd0);
        #2 reset = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("t6 ptr0", 32'(req_ready), 32'h1);
        tick();
        check("t6 grant0", 32'(grant_id), 32'd0);
        req_valid = 4'h0;
        wait_idle("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
